// File: rtl/rca_seq_adder.sv
// rca_seq_adder: multi-cycle ripple-carry adder, CHUNK bits per clock, registered carry between chunks.
// Latency: operands accepted at edge k -> out_valid after edge k+N_CHUNKS; one op per N_CHUNKS+2 cycles.
// Backpressure: result held in DONE while out_ready is low; in_ready only high in IDLE.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, cin, and sub when RCA_SUB_EN is defined)
//   out_valid/out_ready result handshake (sum, cout, ovf)
// Optional feature macro: RCA_SUB_EN adds the sub port (a - b - cin computed as a + ~b + ~cin).

module rca_seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef RCA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

  generate
    if ((WIDTH < 1) || (CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
      $error("rca_seq_adder: WIDTH must be >= 1 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t state_q, state_d;

  // Operands and sum viewed as arrays of chunks so the active chunk is a plain index.
  logic [N_CHUNKS-1:0][CHUNK-1:0] a_q;
  logic [N_CHUNKS-1:0][CHUNK-1:0] b_q;
  logic [N_CHUNKS-1:0][CHUNK-1:0] sum_q;
  logic                           carry_q;
  logic [IDX_W-1:0]               idx_q;
  logic                           cout_q;
  logic                           ovf_q;

  logic                           sub_eff;
  logic                           accept;
  logic [CHUNK:0]                 chunk_res;

`ifdef RCA_SUB_EN
  assign sub_eff = sub;
`else
  assign sub_eff = 1'b0;
`endif

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid && !rst) state_d = ADD;
      end
      ADD: begin
        if (idx_q == LAST_IDX) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  // One CHUNK-bit ripple per cycle; this is the whole critical path.
  assign chunk_res = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + (CHUNK+1)'(carry_q);

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= a;
            // Subtraction folds into addition: invert b and the carry-in once at accept.
            b_q     <= b ^ {WIDTH{sub_eff}};
            carry_q <= cin ^ sub_eff;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
          end
        end
        ADD: begin
          sum_q[idx_q] <= chunk_res[CHUNK-1:0];
          carry_q      <= chunk_res[CHUNK];
          if (idx_q == LAST_IDX) begin
            cout_q <= chunk_res[CHUNK];
            // Top chunk's MSB is the sum sign bit being written this cycle.
            ovf_q  <= (a_q[N_CHUNKS-1][CHUNK-1] == b_q[N_CHUNKS-1][CHUNK-1]) &&
                      (chunk_res[CHUNK-1] != a_q[N_CHUNKS-1][CHUNK-1]);
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_rca_seq_adder.sv
// Directed self-checking bench for rca_seq_adder (WIDTH=16, CHUNK=4).
// Inputs driven on the falling edge or 1 time unit after the rising edge; outputs sampled the same way.
// Subtraction vectors are included only when RCA_SUB_EN is defined.

module tb_rca_seq_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub_r;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rca_seq_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef RCA_SUB_EN
    .sub       (sub_r),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present operands on a falling edge, check in_ready, let the rising edge accept them.
  // Operands are scrambled right after the accept edge to show they are not re-sampled.
  task automatic accept_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                           input logic tcin, input logic tsub);
    @(negedge clk);
    a = ta; b = tb_v; cin = tcin; sub_r = tsub; in_valid = 1'b1;
    chk({tag, " in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 16'hA5A5; b = 16'h5A5A; cin = ~tcin; sub_r = ~tsub;
  endtask

  // Count rising edges after the accept edge until out_valid is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic tcin, input logic tsub,
                        input logic [15:0] esum, input logic ecout, input logic eovf);
    int lat;
    accept_op(tag, ta, tb_v, tcin, tsub);
    wait_done(lat);
    chk({tag, " latency"}, lat, 4);
    chk({tag, " sum"}, sum, esum);
    chk({tag, " cout"}, cout, ecout);
    chk({tag, " ovf"}, ovf, eovf);
    chk({tag, " in_ready_busy"}, in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " out_valid_drop"}, out_valid, 0);
    chk({tag, " sum_held"}, sum, esum);
    chk({tag, " in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub_r = 1'b0;

    // Reset state
    #1;
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst sum", sum, 0);
    chk("rst cout", cout, 0);
    chk("rst ovf", ovf, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst in_ready", in_ready, 1);

    // Basic additions
    run_op("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_cin_only",  16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
    run_op("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("add_8000_8000", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("add_0f0f_00f1", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);

    // Backpressure: hold DONE for 10 cycles while offering new operands
    accept_op("bp", 16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_done(lat);
    chk("bp latency", lat, 4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp out_valid", out_valid, 1);
      chk("bp sum", sum, 16'h3333);
      chk("bp in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp release out_valid", out_valid, 0);
    chk("bp release in_ready", in_ready, 1);
    chk("bp release sum", sum, 16'h3333);

    // Reset during the second ADD cycle discards the operation
    accept_op("rst_mid", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid in_ready", in_ready, 0);
    chk("rst_mid out_valid", out_valid, 0);
    chk("rst_mid sum", sum, 0);
    chk("rst_mid cout", cout, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("rst_mid no_output", seen, 0);
    chk("rst_mid cout_idle", cout, 0);
    run_op("after_rst_3_4", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

    // Reset wins over a simultaneous out_ready in DONE
    accept_op("rst_done", 16'h0101, 16'h0202, 1'b0, 1'b0);
    wait_done(lat);
    chk("rst_done sum_before", sum, 16'h0303);
    @(negedge clk);
    out_ready = 1'b1; rst = 1'b1;
    #1;
    chk("rst_done sum", sum, 0);
    chk("rst_done out_valid", out_valid, 0);
    @(negedge clk);
    out_ready = 1'b0; rst = 1'b0;
    #1;
    chk("rst_done in_ready", in_ready, 1);

`ifdef RCA_SUB_EN
    run_op("sub_5_7",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_8000_1",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_9_3_bin",  16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
